// File: rtl/zbuff_rmw_ctrl_if.sv
// Sample handshake, clear control, SRAM port and statistics bundle for the z-buffer depth sequencer.
// master = upstream/SRAM side, slave = the controller.
interface zbuff_rmw_ctrl_if #(
  parameter int SIGFIG = 24,
  parameter int COLORP = 12,
  parameter int W_L2   = 6,
  parameter int H_L2   = 6,
  parameter int SS_L2  = 2
);
  localparam int AW = W_L2 + H_L2 + 2 * SS_L2;
  localparam int DW = SIGFIG + 3 * COLORP;

  logic [1:0]        ss_w_lg2_U;
  logic              clear_req_H;
  logic              clear_busy_H;
  logic              clear_done_H;
  logic              in_valid_H;
  logic              in_ready_H;
  logic [W_L2-1:0]   x_ind_U;
  logic [H_L2-1:0]   y_ind_U;
  logic [SS_L2-1:0]  x_ss_U;
  logic [SS_L2-1:0]  y_ss_U;
  logic [SIGFIG-1:0] depth_U;
  logic [SIGFIG-1:0] color_U [3];
  logic              mem_en_H;
  logic              mem_we_H;
  logic [AW-1:0]     mem_addr_U;
  logic [DW-1:0]     mem_wdata_U;
  logic [DW-1:0]     mem_rdata_U;
  logic [31:0]       pass_cnt_U;
  logic [31:0]       fail_cnt_U;

  modport master (
    output ss_w_lg2_U, clear_req_H, in_valid_H, x_ind_U, y_ind_U, x_ss_U, y_ss_U,
           depth_U, color_U, mem_rdata_U,
    input  clear_busy_H, clear_done_H, in_ready_H, mem_en_H, mem_we_H, mem_addr_U,
           mem_wdata_U, pass_cnt_U, fail_cnt_U
  );

  modport slave (
    input  ss_w_lg2_U, clear_req_H, in_valid_H, x_ind_U, y_ind_U, x_ss_U, y_ss_U,
           depth_U, color_U, mem_rdata_U,
    output clear_busy_H, clear_done_H, in_ready_H, mem_en_H, mem_we_H, mem_addr_U,
           mem_wdata_U, pass_cnt_U, fail_cnt_U
  );
endinterface

// File: rtl/zbuff_rmw_ctrl.sv
// Z-buffer depth-test sequencer: read-compare-conditional-write per sample on a single-port
// depth/color SRAM, plus a full-buffer clear sweep.
module zbuff_rmw_ctrl #(
  parameter int SIGFIG = 24,
  parameter int COLORP = 12,
  parameter int W_L2   = 6,
  parameter int H_L2   = 6,
  parameter int SS_L2  = 2
) (
  input  logic            clk,
  input  logic            rst,
  zbuff_rmw_ctrl_if.slave bus
);
  localparam int AW   = W_L2 + H_L2 + 2 * SS_L2;
  localparam int DW   = SIGFIG + 3 * COLORP;
  localparam int SSLW = (SS_L2 < 2) ? 1 : $clog2(SS_L2 + 1);
  localparam logic [DW-1:0] CLR_WORD = {{SIGFIG{1'b1}}, {(3 * COLORP){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_CMP, ST_CLEAR} state_t;

  function automatic logic [SSLW-1:0] clamp_ssl(input logic [1:0] ss);
    if (int'(ss) > SS_L2) return SSLW'(SS_L2);
    return SSLW'(ss);
  endfunction

  // Pixel index sits above the subsample field; subsample bits beyond ssl are masked off.
  function automatic logic [AW-1:0] sample_addr(input logic [SSLW-1:0] ssl,
                                                input logic [H_L2-1:0] y, input logic [W_L2-1:0] x,
                                                input logic [SS_L2-1:0] ys, input logic [SS_L2-1:0] xs);
    logic [AW-1:0] m;
    m = (AW'(1) << ssl) - AW'(1);
    return (AW'({y, x}) << (2 * ssl)) | ((AW'(ys) & m) << ssl) | (AW'(xs) & m);
  endfunction

  state_t              state_reg, state_next;
  logic [AW-1:0]       addr_reg;
  logic [SIGFIG-1:0]   depth_reg;
  logic [3*COLORP-1:0] color_reg;
  logic                pend_reg;
  logic [SSLW-1:0]     ssl_reg;
  logic [AW-1:0]       clr_addr_reg;
  logic                done_reg;
  logic [31:0]         pass_cnt_reg, fail_cnt_reg;

  logic [SSLW-1:0]     in_ssl;
  logic [AW-1:0]       in_addr;
  logic [3*COLORP-1:0] color_pk;
  logic [AW-1:0]       clr_last;
  logic                depth_win;
  logic                accept, clr_start;
  logic                en_c, we_c, rdy_c;
  logic [AW-1:0]       addr_c;
  logic [DW-1:0]       wdata_c;

  for (genvar gi = 0; gi < 3; gi++) begin : g_color
    assign color_pk[(2-gi)*COLORP +: COLORP] = bus.color_U[gi][COLORP-1:0];
  end

  assign in_ssl    = clamp_ssl(bus.ss_w_lg2_U);
  assign in_addr   = sample_addr(in_ssl, bus.y_ind_U, bus.x_ind_U, bus.y_ss_U, bus.x_ss_U);
  assign clr_last  = {AW{1'b1}} >> (2 * (SS_L2 - int'(ssl_reg)));
  assign depth_win = depth_reg < bus.mem_rdata_U[DW-1 -: SIGFIG];

  always_comb begin
    state_next = state_reg;
    en_c       = 1'b0;
    we_c       = 1'b0;
    rdy_c      = 1'b0;
    addr_c     = '0;
    wdata_c    = '0;
    accept     = 1'b0;
    clr_start  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // A clear request (new or deferred from CMP) wins over a waiting sample.
        if (pend_reg || bus.clear_req_H) begin
          clr_start  = 1'b1;
          state_next = ST_CLEAR;
        end else begin
          rdy_c = 1'b1;
          if (bus.in_valid_H) begin
            accept     = 1'b1;
            en_c       = 1'b1;
            addr_c     = in_addr;
            state_next = ST_CMP;
          end
        end
      end
      ST_CMP: begin
        if (depth_win) begin
          en_c    = 1'b1;
          we_c    = 1'b1;
          addr_c  = addr_reg;
          wdata_c = {depth_reg, color_reg};
        end
        state_next = ST_IDLE;
      end
      ST_CLEAR: begin
        en_c    = 1'b1;
        we_c    = 1'b1;
        addr_c  = clr_addr_reg;
        wdata_c = CLR_WORD;
        if (clr_addr_reg == clr_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      depth_reg    <= '0;
      color_reg    <= '0;
      pend_reg     <= 1'b0;
      ssl_reg      <= '0;
      clr_addr_reg <= '0;
      done_reg     <= 1'b0;
      pass_cnt_reg <= '0;
      fail_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == ST_CLEAR) && (state_next == ST_IDLE);
      if (accept) begin
        addr_reg  <= in_addr;
        depth_reg <= bus.depth_U;
        color_reg <= color_pk;
      end
      if (clr_start) begin
        ssl_reg      <= in_ssl;
        clr_addr_reg <= '0;
        pend_reg     <= 1'b0;
        pass_cnt_reg <= '0;
        fail_cnt_reg <= '0;
      end else if (state_reg == ST_CLEAR) begin
        clr_addr_reg <= clr_addr_reg + AW'(1);
      end
      if (state_reg == ST_CMP) begin
        if (bus.clear_req_H) pend_reg <= 1'b1;
        if (depth_win) pass_cnt_reg <= pass_cnt_reg + 32'd1;
        else           fail_cnt_reg <= fail_cnt_reg + 32'd1;
      end
    end
  end

  // Reset gates the combinational outputs so an abort stops SRAM traffic in the same cycle.
  assign bus.mem_en_H     = en_c & ~rst;
  assign bus.mem_we_H     = we_c & ~rst;
  assign bus.mem_addr_U   = rst ? '0 : addr_c;
  assign bus.mem_wdata_U  = rst ? '0 : wdata_c;
  assign bus.in_ready_H   = rdy_c & ~rst;
  assign bus.clear_busy_H = (state_reg == ST_CLEAR) & ~rst;
  assign bus.clear_done_H = done_reg & ~rst;
  assign bus.pass_cnt_U   = pass_cnt_reg;
  assign bus.fail_cnt_U   = fail_cnt_reg;
endmodule

// File: tb/tb_zbuff_rmw_ctrl.sv
// Scoreboard bench for zbuff_rmw_ctrl: behavioural SRAM, reference depth model, bus monitor.
module tb_zbuff_rmw_ctrl;
  localparam int SIGFIG = 24, COLORP = 12, W_L2 = 6, H_L2 = 6, SS_L2 = 2;
  localparam int AW = W_L2 + H_L2 + 2 * SS_L2;
  localparam int DW = SIGFIG + 3 * COLORP;
  localparam logic [DW-1:0] CLR_WORD = {{SIGFIG{1'b1}}, {(3 * COLORP){1'b0}}};

  typedef struct {
    int              addr;
    bit              wr;
    logic [DW-1:0]   wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  zbuff_rmw_ctrl_if #(.SIGFIG(SIGFIG), .COLORP(COLORP), .W_L2(W_L2), .H_L2(H_L2), .SS_L2(SS_L2)) bus ();
  zbuff_rmw_ctrl #(.SIGFIG(SIGFIG), .COLORP(COLORP), .W_L2(W_L2), .H_L2(H_L2), .SS_L2(SS_L2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic [DW-1:0]     sram [0:(1<<AW)-1];
  logic [DW-1:0]     rdata_q = '0;
  logic [SIGFIG-1:0] ref_depth [0:(1<<AW)-1];
  exp_t              sb_q [$];

  int n_vec = 0, n_err = 0;
  int mdl_pass = 0, mdl_fail = 0;
  int clr_exp = 0, clr_total = 0;
  bit cmp_slot = 0, prev_busy = 0;
  logic [AW-1:0] rd_addr_seen;

  int cur_ss, cur_x, cur_y, cur_xs, cur_ys;
  logic [SIGFIG-1:0] cur_d, cur_r, cur_g, cur_b;

  always @(posedge clk) begin
    if (bus.mem_en_H) begin
      if (bus.mem_we_H) sram[bus.mem_addr_U] <= bus.mem_wdata_U;
      else              rdata_q <= sram[bus.mem_addr_U];
    end
  end
  assign bus.mem_rdata_U = rdata_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_addr(input int ss, input int x, input int y, input int xs, input int ys);
    int s = (ss > SS_L2) ? SS_L2 : ss;
    int m = (1 << s) - 1;
    return (y << (W_L2 + 2 * s)) | (x << (2 * s)) | ((ys & m) << s) | (xs & m);
  endfunction

  task automatic load_sample();
    bus.ss_w_lg2_U = cur_ss[1:0];
    bus.x_ind_U    = cur_x[W_L2-1:0];
    bus.y_ind_U    = cur_y[H_L2-1:0];
    bus.x_ss_U     = cur_xs[SS_L2-1:0];
    bus.y_ss_U     = cur_ys[SS_L2-1:0];
    bus.depth_U    = cur_d;
    bus.color_U[0] = cur_r;
    bus.color_U[1] = cur_g;
    bus.color_U[2] = cur_b;
  endtask

  task automatic push_exp();
    exp_t e;
    e.addr  = exp_addr(cur_ss, cur_x, cur_y, cur_xs, cur_ys);
    e.wr    = cur_d < ref_depth[e.addr];
    if (e.wr) ref_depth[e.addr] = cur_d;
    e.wdata = {cur_d, cur_r[COLORP-1:0], cur_g[COLORP-1:0], cur_b[COLORP-1:0]};
    sb_q.push_back(e);
  endtask

  task automatic set_sample(input int ss, input int x, input int y, input int xs, input int ys,
                            input logic [SIGFIG-1:0] d, input logic [SIGFIG-1:0] r,
                            input logic [SIGFIG-1:0] g, input logic [SIGFIG-1:0] b);
    cur_ss = ss; cur_x = x; cur_y = y; cur_xs = xs; cur_ys = ys;
    cur_d = d; cur_r = r; cur_g = g; cur_b = b;
    load_sample();
  endtask

  // Presents one sample and returns #1 after the accepting edge (i.e. in the CMP cycle).
  task automatic send(input int ss, input int x, input int y, input int xs, input int ys,
                      input logic [SIGFIG-1:0] d, input logic [SIGFIG-1:0] r,
                      input logic [SIGFIG-1:0] g, input logic [SIGFIG-1:0] b);
    bit acc = 0;
    set_sample(ss, x, y, xs, ys, d, r, g, b);
    bus.in_valid_H = 1'b1;
    for (int k = 0; k < 8 && !acc; k++) begin
      @(negedge clk);
      if (bus.in_ready_H) begin
        acc = 1;
        push_exp();
      end
      @(posedge clk); #1;
    end
    check("accept", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_clear(input int ss);
    int s = (ss > SS_L2) ? SS_L2 : ss;
    bus.ss_w_lg2_U  = ss[1:0];
    clr_total       = 1 << (W_L2 + H_L2 + 2 * s);
    bus.clear_req_H = 1'b1;
    @(posedge clk); #1;
    bus.clear_req_H = 1'b0;
  endtask

  task automatic wait_clear();
    bit seen = 0;
    for (int k = 0; k < clr_total + 50 && !seen; k++) begin
      @(negedge clk);
      if (bus.clear_done_H) seen = 1;
    end
    check("clr_done_seen", 64'(seen), 64'd1);
    for (int a = 0; a < clr_total; a++) ref_depth[a] = '1;
    @(posedge clk); #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_pass"}, 64'(bus.pass_cnt_U), 64'(mdl_pass));
    check({tag, "_fail"}, 64'(bus.fail_cnt_U), 64'(mdl_fail));
  endtask

  // Bus monitor: every cycle is classified as reset, CMP slot, clear sweep or idle/read.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out", 64'({bus.mem_en_H, bus.in_ready_H, bus.clear_busy_H, bus.clear_done_H}), 64'd0);
      cmp_slot = 0;
      prev_busy = 0;
      mdl_pass = 0;
      mdl_fail = 0;
      sb_q.delete();
    end else begin
      if (cmp_slot) begin
        cmp_slot = 0;
        check("cmp_rdy", 64'(bus.in_ready_H), 64'd0);
        if (sb_q.size() == 0) begin
          check("sb_depth", 64'(sb_q.size()), 64'd1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("rd_addr", 64'(rd_addr_seen), 64'(e.addr));
          if (e.wr) begin
            check("wr_acc", 64'({bus.mem_en_H, bus.mem_we_H}), 64'b11);
            check("wr_addr", 64'(bus.mem_addr_U), 64'(e.addr));
            check("wr_data", 64'(bus.mem_wdata_U), 64'(e.wdata));
            mdl_pass++;
          end else begin
            check("nowr_acc", 64'({bus.mem_en_H, bus.mem_we_H}), 64'b00);
            mdl_fail++;
          end
        end
      end else if (bus.clear_busy_H) begin
        if (!prev_busy) begin
          clr_exp = 0;
          mdl_pass = 0;
          mdl_fail = 0;
        end
        check("clr_acc", 64'({bus.mem_en_H, bus.mem_we_H, bus.in_ready_H}), 64'b110);
        check("clr_addr", 64'(bus.mem_addr_U), 64'(clr_exp));
        check("clr_data", 64'(bus.mem_wdata_U), 64'(CLR_WORD));
        clr_exp++;
      end else begin
        if (bus.mem_en_H && !bus.mem_we_H) begin
          cmp_slot = 1;
          rd_addr_seen = bus.mem_addr_U;
        end else begin
          check("idle_acc", 64'({bus.mem_en_H, bus.mem_we_H}), 64'b00);
        end
        check("done", 64'(bus.clear_done_H), 64'(prev_busy));
        if (prev_busy) check("clr_cnt", 64'(clr_exp), 64'(clr_total));
      end
      prev_busy = bus.clear_busy_H;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int n_acc;
    for (int a = 0; a < (1 << AW); a++) begin
      sram[a] = '0;
      ref_depth[a] = '0;
    end
    rst = 1'b1;
    bus.clear_req_H = 1'b0;
    bus.in_valid_H  = 1'b0;
    set_sample(0, 0, 0, 0, 0, '0, '0, '0, '0);
    idle(3);
    @(negedge clk);
    check("rst_pass", 64'(bus.pass_cnt_U), 64'd0);
    check("rst_fail", 64'(bus.fail_cnt_U), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rdy_post_rst", 64'(bus.in_ready_H), 64'd1);
    @(posedge clk); #1;

    // Full clear at ssl=0; a second request mid-sweep must be ignored.
    issue_clear(0);
    idle(10);
    bus.clear_req_H = 1'b1;
    idle(1);
    bus.clear_req_H = 1'b0;
    wait_clear();

    send(0, 3, 2, 0, 0, 24'h100, 24'd1, 24'd2, 24'd3);
    bus.in_valid_H = 1'b0;
    idle(2);
    check_counts("first");
    send(0, 3, 2, 0, 0, 24'h100, 24'd4, 24'd5, 24'd6);
    send(0, 3, 2, 0, 0, 24'h200, 24'd7, 24'd8, 24'd9);
    send(0, 3, 2, 0, 0, 24'h0FF, 24'hABC, 24'h123FFF, 24'h456);
    bus.in_valid_H = 1'b0;
    idle(2);
    check_counts("eqfail");

    // Subsample addressing: clamp at ss=3, masking at ss=1.
    send(2, 1, 0, 3, 2, 24'h80, 24'd1, 24'd1, 24'd1);
    send(3, 1, 0, 3, 2, 24'h50, 24'd2, 24'd2, 24'd2);
    send(1, 1, 0, 3, 3, 24'h40, 24'd3, 24'd3, 24'd3);
    send(2, 63, 63, 3, 3, 24'h10, 24'd4, 24'd4, 24'd4);
    bus.in_valid_H = 1'b0;
    idle(2);
    check_counts("subsamp");

    // in_valid held for 10 cycles: one acceptance every other cycle.
    set_sample(0, $urandom_range(63), $urandom_range(63), 0, 0, 24'($urandom),
               24'($urandom), 24'($urandom), 24'($urandom));
    bus.in_valid_H = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      found = 0;
      @(negedge clk);
      if (bus.in_ready_H) begin
        push_exp();
        n_acc++;
        found = 1;
      end
      @(posedge clk); #1;
      if (found) set_sample(0, $urandom_range(63), $urandom_range(63), $urandom_range(3),
                            $urandom_range(3), 24'($urandom), 24'($urandom), 24'($urandom),
                            24'($urandom));
    end
    bus.in_valid_H = 1'b0;
    check("b2b_acc", 64'(n_acc), 64'd5);
    idle(2);
    check_counts("b2b");

    // Clear wins over a simultaneous valid sample.
    set_sample(0, 5, 5, 0, 0, 24'h1, 24'd1, 24'd1, 24'd1);
    bus.in_valid_H = 1'b1;
    bus.ss_w_lg2_U = 2'd0;
    clr_total = 1 << (W_L2 + H_L2);
    bus.clear_req_H = 1'b1;
    @(negedge clk);
    check("prio_rdy", 64'(bus.in_ready_H), 64'd0);
    @(posedge clk); #1;
    bus.clear_req_H = 1'b0;
    bus.in_valid_H = 1'b0;
    wait_clear();
    check_counts("prio_clr");

    // Clear requested during CMP: the pending write finishes first.
    send(0, 10, 20, 0, 0, 24'h333, 24'd7, 24'd7, 24'd7);
    bus.in_valid_H = 1'b0;
    issue_clear(0);
    wait_clear();
    check_counts("pend_clr");

    // Reset during CMP: no write, counters return to zero.
    send(0, 4, 4, 0, 0, 24'h22, 24'd1, 24'd1, 24'd1);
    bus.in_valid_H = 1'b0;
    idle(2);
    check_counts("pre_abort");
    send(0, 4, 5, 0, 0, 24'h22, 24'd1, 24'd1, 24'd1);
    bus.in_valid_H = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_cmp_en", 64'(bus.mem_en_H), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_cmp_pass", 64'(bus.pass_cnt_U), 64'd0);
    @(posedge clk); #1;

    // Reset in the middle of a clear sweep.
    issue_clear(0);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (bus.clear_busy_H && bus.mem_addr_U == AW'(100)) found = 1;
    end
    check("clr_at100", 64'(found), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_clr_en", 64'(bus.mem_en_H), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_clr_busy", 64'(bus.clear_busy_H), 64'd0);
    check("abort_clr_rdy", 64'(bus.in_ready_H), 64'd1);
    idle(3);
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
